// File: rtl/clk_div_mon.sv
// Divided-clock monitor: measures clk_div periods against DIV, tracks lock and counts errors.
// Define CLK_DIV_MON_DUTY_EN to add high-time measurement and a duty-cycle check.
`timescale 1ns/1ps
module clk_div_mon #(
    parameter int unsigned DIV      = 9,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_div,
    input  logic          en,
    input  logic          clr,
    output logic          locked,
    output logic          err,
    output logic [7:0]    err_cnt,
    output logic [CW-1:0] period
`ifdef CLK_DIV_MON_DUTY_EN
    ,
    output logic [CW-1:0] high_time
`endif
);

    localparam int unsigned GW  = 4;
    localparam int unsigned EW  = 8;
    localparam int unsigned TMO = 2 * DIV;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACQ  = 3'd1,
        MEAS = 3'd2,
        LOCK = 3'd3,
        FAIL = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   good_run_q, good_run_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic [EW-1:0]   err_cnt_q, err_cnt_d;
    logic [CW-1:0]   period_q, period_d;
    logic            rise_c;
    logic            duty_ok_c;
    logic            bad_c;

    assign rise_c = sync2_q & ~prev_q;

    // Two-flop synchronizer plus history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= clk_div;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rise_c) begin
            cnt_d = CW'(1);
        end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

`ifdef CLK_DIV_MON_DUTY_EN
    logic          fall_c;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] high_time_q, high_time_d;

    assign fall_c = ~sync2_q & prev_q;

    always_comb begin
        hcnt_d      = hcnt_q;
        high_time_d = high_time_q;
        if (rise_c) begin
            hcnt_d = CW'(1);
        end else if (sync2_q && hcnt_q != {CW{1'b1}}) begin
            hcnt_d = hcnt_q + CW'(1);
        end
        if (fall_c) begin
            high_time_d = hcnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q      <= '0;
            high_time_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            high_time_q <= high_time_d;
        end
    end

    // Either rounding of DIV/2 counts as a 50% duty cycle
    assign duty_ok_c = (high_time_q == CW'(DIV / 2)) || (high_time_q == CW'((DIV + 1) / 2));
    assign high_time = high_time_q;
`else
    assign duty_ok_c = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        locked_d   = locked_q;
        period_d   = period_q;
        bad_c      = 1'b0;
        if (!en) begin
            state_d    = IDLE;
            good_run_d = '0;
            locked_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    if (rise_c) begin
                        state_d = MEAS;
                    end
                end
                MEAS, LOCK, FAIL: begin
                    if (rise_c) begin
                        period_d = cnt_q;
                        if (cnt_q == CW'(DIV) && duty_ok_c) begin
                            if (good_run_q != GW'(LOCK_CNT)) begin
                                good_run_d = good_run_q + GW'(1);
                            end
                            if (good_run_d == GW'(LOCK_CNT)) begin
                                state_d  = LOCK;
                                locked_d = 1'b1;
                            end
                        end else begin
                            bad_c   = 1'b1;
                            state_d = FAIL;
                        end
                    end else if (cnt_q == CW'(TMO)) begin
                        // Missing edge: count it as an error and reacquire
                        bad_c   = 1'b1;
                        state_d = ACQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (bad_c) begin
            good_run_d = '0;
            locked_d   = 1'b0;
        end
    end

    // A bad event in a clear cycle wins over the clear
    always_comb begin
        err_d     = clr ? 1'b0 : err_q;
        err_cnt_d = clr ? '0 : err_cnt_q;
        if (bad_c) begin
            err_d = 1'b1;
            if (err_cnt_d != {EW{1'b1}}) begin
                err_cnt_d = err_cnt_d + EW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            good_run_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            good_run_q <= good_run_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            period_q   <= period_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign period  = period_q;

endmodule

// File: tb/tb_clk_div_mon.sv
// Randomized bench for clk_div_mon with a cycle-level behavioural reference model.
`timescale 1ns/1ps
module tb_clk_div_mon;

    localparam int DIV      = 9;
    localparam int LOCK_CNT = 4;
    localparam int CW       = 8;
    localparam int TMO      = 2 * DIV;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          clk_div = 1'b0;
    logic          en      = 1'b0;
    logic          clr     = 1'b0;
    logic          locked;
    logic          err;
    logic [7:0]    err_cnt;
    logic [CW-1:0] period;
`ifdef CLK_DIV_MON_DUTY_EN
    logic [CW-1:0] high_time;
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    clk_div_mon #(.DIV(DIV), .LOCK_CNT(LOCK_CNT), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .en        (en),
        .clr       (clr),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .period    (period)
`ifdef CLK_DIV_MON_DUTY_EN
        ,
        .high_time (high_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: modes 0=idle, 1=acquire, 2=checking; raw samples delayed by
    // two edges give the synchronized level, and periods are differences of rise cycles.
    int m_mode, m_run, m_errc, m_per, m_hi, cyc, r_last;
    bit m_lock, m_err, h1, h2, h3;

    always @(posedge clk or posedge rst) begin : model
        int cnt;
        bit rise, fall, bad, duty;
        if (rst) begin
            m_mode = 0; m_run = 0; m_lock = 0; m_err = 0; m_errc = 0;
            m_per = 0; m_hi = 0; cyc = 0; r_last = 0; h1 = 0; h2 = 0; h3 = 0;
        end else begin
            rise = h2 && !h3;
            fall = !h2 && h3;
            cnt  = sat(cyc - r_last, 255);
            duty = 1'b1;
            if (DUTY_ON) duty = (m_hi == DIV / 2) || (m_hi == (DIV + 1) / 2);
            bad = 1'b0;
            if (!en) begin
                m_mode = 0; m_run = 0; m_lock = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (rise) m_mode = 2;
            end else if (rise) begin
                m_per = cnt;
                if (cnt == DIV && duty) begin
                    m_run = sat(m_run + 1, LOCK_CNT);
                    if (m_run == LOCK_CNT) m_lock = 1;
                end else begin
                    bad = 1'b1;
                end
            end else if (cnt == TMO) begin
                bad = 1'b1;
                m_mode = 1;
            end
            if (bad) begin m_run = 0; m_lock = 0; end
            if (clr) begin m_err = 0; m_errc = 0; end
            if (bad) begin m_err = 1; m_errc = sat(m_errc + 1, 255); end
            if (fall) m_hi = sat(cyc - r_last, 255);
            if (rise) r_last = cyc;
            h3 = h2; h2 = h1; h1 = clk_div;
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("locked",  int'(locked),  int'(m_lock));
        check("err",     int'(err),     int'(m_err));
        check("err_cnt", int'(err_cnt), m_errc);
        check("period",  int'(period),  m_per);
`ifdef CLK_DIV_MON_DUTY_EN
        check("high_time", int'(high_time), m_hi);
`endif
    end

    task automatic drive_level(input bit v, input int n, input bit rnd);
        repeat (n) begin
            @(posedge clk);
            #($urandom_range(1, 9));
            clk_div = v;
            if (rnd) begin
                clr = ($urandom_range(0, 19) == 0);
                en  = ($urandom_range(0, 59) != 0);
            end
        end
    endtask

    task automatic run_periods(input int per, input int high, input int n, input bit rnd = 1'b0);
        repeat (n) begin
            drive_level(1'b1, high, rnd);
            drive_level(1'b0, per - high, rnd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int per, hi;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked",  int'(locked),  0);
        check("rst_err",     int'(err),     0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_period",  int'(period),  0);
        rst = 1'b0;
        en  = 1'b1;

        run_periods(9, 5, 4);
        check("no_lock_rise4", int'(locked), 0);
        run_periods(9, 5, 1);
        check("lock_rise5",   int'(locked),  1);
        check("lock_period",  int'(period),  9);
        check("lock_err",     int'(err),     0);
        check("lock_err_cnt", int'(err_cnt), 0);

        run_periods(10, 5, 1);
        run_periods(9, 5, 1);
        check("long_period",  int'(period),  10);
        check("long_locked",  int'(locked),  0);
        check("long_err",     int'(err),     1);
        check("long_err_cnt", int'(err_cnt), 1);
        run_periods(9, 5, 4);
        check("relock",       int'(locked),  1);
        check("relock_err",   int'(err),     1);

        drive_level(1'b0, 30, 1'b0);
        check("tmo_locked",   int'(locked),  0);
        check("tmo_err_cnt",  int'(err_cnt), 2);
        run_periods(9, 5, 5);
        check("tmo_relock",   int'(locked),  1);
        check("tmo_err_cnt2", int'(err_cnt), 2);

        // Short period whose closing rise pulse coincides with clr
        run_periods(8, 4, 1);
        drive_level(1'b1, 1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clr_bad_err",     int'(err),     1);
        check("clr_bad_err_cnt", int'(err_cnt), 1);
        drive_level(1'b1, 1, 1'b0);
        drive_level(1'b0, 4, 1'b0);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clr_err",     int'(err),     0);
        check("clr_err_cnt", int'(err_cnt), 0);

        run_periods(9, 5, 6);
        check("pre_rst_locked", int'(locked), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_locked",  int'(locked),  0);
        check("arst_err",     int'(err),     0);
        check("arst_err_cnt", int'(err_cnt), 0);
        check("arst_period",  int'(period),  0);
        #2 rst = 1'b0;
        run_periods(9, 5, 5);
        check("rst_relock",   int'(locked), 1);
        check("rst_relock_p", int'(period), 9);

        run_periods(9, 2, 5);
        check("duty_err",    int'(err),    int'(DUTY_ON));
        check("duty_locked", int'(locked), int'(!DUTY_ON));
`ifdef CLK_DIV_MON_DUTY_EN
        check("duty_high_time", int'(high_time), 2);
`endif

        run_periods(9, 5, 6);
        @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("en_off_locked", int'(locked), 0);
        en = 1'b1;

        repeat (150) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: per = 9;
                5:             per = 8;
                6:             per = 10;
                default:       per = $urandom_range(2, 25);
            endcase
            if (per == 9 && $urandom_range(0, 3) != 0) hi = $urandom_range(4, 5);
            else hi = $urandom_range(1, per - 1);
            run_periods(per, hi, 1, 1'b1);
        end
        clr = 1'b0;
        en  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_mon.md
CLK_DIV_MON -- requirements
Module: clk_div_mon

Interface
REQ-001 Parameter DIV, default 9: expected divided-clock period in clk cycles; legal range 2..127.
REQ-002 Parameter LOCK_CNT, default 4: consecutive good periods required to assert locked; legal range 1..15.
REQ-003 Parameter CW, default 8: width of the period counter and of the period output.
REQ-004 Port clk, input, 1 bit: reference clock, the only clock; all flops rise-edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port clk_div, input, 1 bit: divided clock under test, asynchronous to the sampling point (edges may come from either clk edge).
REQ-007 Port en, input, 1 bit: monitor enable.
REQ-008 Port clr, input, 1 bit: synchronous clear of err and err_cnt.
REQ-009 Port locked, output, 1 bit: LOCK_CNT consecutive good periods seen.
REQ-010 Port err, output, 1 bit: sticky error flag.
REQ-011 Port err_cnt, output, 8 bits: count of bad events, saturating at 255.
REQ-012 Port period, output, CW bits: last measured rise-to-rise period in clk cycles.
REQ-013 Port high_time, output, CW bits: last measured high time in clk cycles; present only with the macro defined (REQ-030).

Function
REQ-014 clk_div SHALL pass through a 2-flop synchronizer and then a history flop; rise = sync&~prev, fall = ~sync&prev.
REQ-015 Counter cnt SHALL load 1 on a rise, increment on other cycles, and saturate at 2^CW-1; at rise cycle t0+DIV it SHALL hold DIV.
REQ-016 The FSM SHALL have states IDLE, ACQ, MEAS, LOCK and FAIL.
REQ-017 IDLE: when en=1, go to ACQ. In any state, en=0 SHALL force IDLE on the next clk, clear locked and good_run, and hold err, err_cnt and period.
REQ-018 ACQ: the first rise SHALL load cnt, move to MEAS, and perform no period check.
REQ-019 MEAS, LOCK, FAIL: each rise SHALL load period<=cnt and classify the period as good iff cnt==DIV (and the duty check passes, REQ-030).
REQ-020 A good period SHALL increment good_run, saturating at LOCK_CNT; when good_run reaches LOCK_CNT, the state SHALL go to LOCK and locked=1 on that clk.
REQ-021 A bad period SHALL: clear good_run, set locked=0, set err=1, increment err_cnt (saturating), and move to FAIL.
REQ-022 FAIL SHALL relock through the same good_run rule as MEAS; err SHALL stay 1 until clr.
REQ-023 Timeout: cnt reaching 2*DIV with no rise, in MEAS, LOCK or FAIL, SHALL be treated as a bad event (REQ-021 minus the period update), and the state SHALL go to ACQ.
REQ-024 clr=1 SHALL clear err and err_cnt on the next clk; if a bad event occurs in the same cycle, the result SHALL be err=1, err_cnt=1.
REQ-025 Latency: an input edge captured at clk edge k SHALL produce the rise/fall pulse in cycle k+1 (registered outputs update at k+2).

Reset
REQ-026 While rst=1, asynchronously and independent of clk, the block SHALL set: state=IDLE, synchronizer, history flop, cnt and good_run=0, locked=0, err=0, err_cnt=0, period=0, high_time=0.
REQ-027 Reset asserted mid-lock SHALL drop locked within the same simulation time step.
REQ-028 After rst deasserts, the first possible period check SHALL occur at the second synchronized rise.

Configuration
REQ-029 Macro CLK_DIV_MON_DUTY_EN SHALL compile in the duty check; when undefined, the high_time port and its logic SHALL be absent and good depends on period only.
REQ-030 With the macro defined: hcnt SHALL count synchronized-high cycles from each rise; on fall, high_time<=hcnt. At the next rise, the duty check passes iff high_time is floor(DIV/2) or ceil(DIV/2) (4 or 5 for DIV=9).

Verification
REQ-031 DIV=9, clk_div at 100MHz/9 with 50% duty, en=1 -> locked=1 at the 5th rise, period=9, err=0, err_cnt=0.
REQ-032 After lock, one 10-cycle period -> period=10, locked=0, err=1, err_cnt=1; four 9-cycle periods -> locked=1, err still 1.
REQ-033 clk_div held low for 30 cycles while locked -> timeout at cnt=18, err_cnt+1, state ACQ, locked=0; relock after 5 rises.
REQ-034 clr pulsed in the same cycle as a bad period -> err=1, err_cnt=1; clr alone -> err=0, err_cnt=0 next clk.
REQ-035 rst pulsed for 3ns while locked -> all outputs 0 immediately; relock after 5 rises.
REQ-036 With CLK_DIV_MON_DUTY_EN defined: 9-cycle period, 2-cycle high -> high_time=2, err=1. Without the macro, the same stimulus -> err=0, locked=1.
